// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache block-fill engines and the memory arbiter.
// Holds the fill state encoding, address split constants and the word-address helper.
package cache_fill_fsm_pkg;

    localparam int ADDR_BITS         = 16;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;
    localparam int BASE_BITS         = ADDR_BITS - BLOCK_OFFSET_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fill_state_e;

    // Byte address of halfword idx inside the block starting at base.
    function automatic logic [ADDR_BITS-1:0] word_address(
        input logic [BASE_BITS-1:0]     base,
        input logic [WORD_IDX_BITS-1:0] idx
    );
        return {base, idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// Halfword counter for the fill engine: synchronous clear, count enable and
// a terminal-count flag when the counter sits on the last word of the block.
module word_counter
    import cache_fill_fsm_pkg::*;
#(
    parameter logic [WORD_IDX_BITS-1:0] LAST = 3'd7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    output logic [WORD_IDX_BITS-1:0] count,
    output logic                     tc
);

    // Counter register; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 3'd0;
        end else if (en) begin
            count <= count + 3'd1;
        end else begin
            count <= count;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: issues eight sequential halfword reads for the missed
// block and streams the returned words into the data array, then writes the tag.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_detected,
    input  logic [ADDR_BITS-1:0]     miss_address,
    input  logic                     mem_grant,
    input  logic                     memory_data_valid,
    input  logic [ADDR_BITS-1:0]     memory_data,
    output logic                     fsm_busy,
    output logic                     mem_read_req,
    output logic [ADDR_BITS-1:0]     memory_address,
    output logic                     write_data_array,
    output logic [WORD_IDX_BITS-1:0] block_word_idx,
    output logic                     write_tag_array,
    output logic                     fill_done
);

    localparam logic [WORD_IDX_BITS-1:0] LAST_WORD = WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

    fill_state_e              state_r;
    fill_state_e              state_nxt_s;
    logic [BASE_BITS-1:0]     base_r;
    logic                     issue_all_r;
    logic [WORD_IDX_BITS-1:0] issue_cnt_s;
    logic [WORD_IDX_BITS-1:0] rcv_cnt_s;
    logic                     issue_tc_s;
    logic                     rcv_tc_s;
    logic                     start_s;
    logic                     issue_en_s;
    logic                     rcv_en_s;
    logic                     set_issue_all_s;
    logic                     accept_s;

    // Data bypasses this block and the low offset bits never reach the address.
    logic unused_s;
    assign unused_s = ^{memory_data, miss_address[BLOCK_OFFSET_BITS-1:0]};

    word_counter #(.LAST(LAST_WORD)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_s),
        .en    (issue_en_s),
        .count (issue_cnt_s),
        .tc    (issue_tc_s)
    );

    word_counter #(.LAST(LAST_WORD)) u_rcv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_s),
        .en    (rcv_en_s),
        .count (rcv_cnt_s),
        .tc    (rcv_tc_s)
    );

    // Fill state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Block base and all-issued flag; base is frozen for the whole fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r      <= '0;
            issue_all_r <= 1'b0;
        end else if (start_s) begin
            base_r      <= miss_address[ADDR_BITS-1:BLOCK_OFFSET_BITS];
            issue_all_r <= 1'b0;
        end else if (set_issue_all_s) begin
            base_r      <= base_r;
            issue_all_r <= 1'b1;
        end else begin
            base_r      <= base_r;
            issue_all_r <= issue_all_r;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt_s      = state_r;
        fsm_busy         = 1'b0;
        mem_read_req     = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        block_word_idx   = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        start_s          = 1'b0;
        issue_en_s       = 1'b0;
        rcv_en_s         = 1'b0;
        set_issue_all_s  = 1'b0;
        accept_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH, ST_DRAIN: begin
                fsm_busy = 1'b1;
                if (state_r == ST_FETCH) begin
                    mem_read_req   = mem_grant;
                    memory_address = word_address(base_r, issue_cnt_s);
                    issue_en_s     = mem_grant;
                    if (mem_grant && issue_tc_s) begin
                        set_issue_all_s = 1'b1;
                        state_nxt_s     = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
                // A return with nothing outstanding cannot belong to this fill.
                accept_s = memory_data_valid && (issue_all_r || (rcv_cnt_s != issue_cnt_s));
                if (accept_s) begin
                    write_data_array = 1'b1;
                    block_word_idx   = rcv_cnt_s;
                    rcv_en_s         = 1'b1;
                    if (rcv_tc_s) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        state_nxt_s     = ST_IDLE;
                    end else begin
                        write_tag_array = 1'b0;
                    end
                end else begin
                    rcv_en_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: the bench acts as a fixed-latency memory
// and compares every cycle against a count-based model of the fill rules.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        mem_grant;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_read_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  block_word_idx;
    logic        write_tag_array;
    logic        fill_done;

    cache_fill_fsm #(.WORDS_PER_BLOCK(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .mem_grant         (mem_grant),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read_req      (mem_read_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .block_word_idx    (block_word_idx),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 4;
    int due_q[$];

    // Reference model: a fill is just a base plus issued/received word counts.
    bit m_active = 1'b0;
    int m_base   = 0;
    int m_iss    = 0;
    int m_rcv    = 0;

    logic        o_busy, o_req, o_wr, o_tag, o_done;
    logic [15:0] o_addr;
    logic [2:0]  o_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic miss, input logic [15:0] addr, input logic grant,
                        input logic rst_i, input logic spur);
        logic        vld;
        logic        fetch, e_busy, e_req, accept, e_last;
        logic [15:0] e_addr;
        vld = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            vld = 1'b1;
            void'(due_q.pop_front());
        end
        if (spur && !vld && (!m_active || m_rcv == m_iss)) vld = 1'b1;
        rst               = rst_i;
        miss_detected     = miss;
        miss_address      = addr;
        mem_grant         = grant;
        memory_data_valid = vld;
        memory_data       = 16'($urandom);

        fetch  = m_active && (m_iss < 8);
        e_busy = m_active ? 1'b1 : miss;
        e_req  = fetch && grant;
        e_addr = fetch ? 16'(m_base * 16 + m_iss * 2) : 16'h0000;
        accept = vld && m_active && (m_rcv < m_iss);
        e_last = accept && (m_rcv == 7);

        #4;
        o_busy = fsm_busy;  o_req = mem_read_req; o_addr = memory_address;
        o_wr   = write_data_array; o_idx = block_word_idx;
        o_tag  = write_tag_array;  o_done = fill_done;
        chk("busy", 32'(o_busy), 32'(e_busy));
        chk("req",  32'(o_req),  32'(e_req));
        if (fetch || !m_active) chk("addr", 32'(o_addr), 32'(e_addr));
        chk("wr",   32'(o_wr),   32'(accept));
        if (accept) chk("idx", 32'(o_idx), 32'(m_rcv));
        chk("tag",  32'(o_tag),  32'(e_last));
        chk("done", 32'(o_done), 32'(e_last));

        if (e_req) due_q.push_back(cyc + lat);
        if (rst_i) begin
            m_active = 1'b0; m_iss = 0; m_rcv = 0;
        end else if (!m_active) begin
            if (miss) begin
                m_active = 1'b1; m_base = int'(addr >> 4); m_iss = 0; m_rcv = 0;
            end
        end else begin
            if (e_req)  m_iss++;
            if (accept) m_rcv++;
            if (e_last) m_active = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input logic [15:0] a, input int gap_lo, input int gap_hi,
                            input int rst_at, input int miss2_at, input int max_c,
                            output int done_at, output int nwr, output int nbusy,
                            output int bad_base, output int late_ev);
        logic        m, g;
        logic [15:0] ad;
        done_at = -1; nwr = 0; nbusy = 0; bad_base = 0; late_ev = 0;
        for (int c = 0; c < max_c; c++) begin
            m  = (c == 0) || (c == miss2_at);
            ad = (c == 0) ? a : ((c == miss2_at) ? 16'hABCD : 16'h0000);
            g  = !(c >= gap_lo && c <= gap_hi);
            tick(m, ad, g, (c == rst_at), 1'b0);
            if (o_busy) nbusy++;
            if (o_wr)   nwr++;
            if (o_req && (o_addr[15:4] != a[15:4])) bad_base++;
            if (c == 1) chk("first_addr", 32'(o_addr), 32'({a[15:4], 4'h0}));
            if (rst_at >= 0 && c == rst_at + 1)
                chk("rst_zero", 32'({o_busy, o_req, o_addr, o_wr, o_tag, o_done}), 32'h0);
            if (rst_at >= 0 && c > rst_at && (o_wr || o_tag || o_done)) late_ev++;
            if (o_done && done_at < 0) begin
                done_at = c;
                break;
            end
        end
    endtask

    initial begin
        int d, w, b, bb, le;
        rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0000;
        mem_grant = 1'b0; memory_data_valid = 1'b0; memory_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;

        // Reset state with idle inputs.
        tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Basic fill, continuous grant, latency 4.
        run_fill(16'h1234, -1, -1, -1, -1, 40, d, w, b, bb, le);
        chk("basic_done_cycle", 32'(d), 32'd12);
        chk("basic_writes", 32'(w), 32'd8);
        chk("basic_busy_cycles", 32'(b), 32'd13);
        chk("basic_base", 32'(bb), 32'd0);

        // Back-to-back: new miss in the cycle after fill_done.
        run_fill(16'h5670, -1, -1, -1, -1, 40, d, w, b, bb, le);
        chk("b2b_done_cycle", 32'(d), 32'd12);
        chk("b2b_writes", 32'(w), 32'd8);

        // Spurious data-valid while idle.
        tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("spur_idle_wr", 32'(o_wr), 32'd0);
        tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("spur_idle_busy", 32'(o_busy), 32'd0);

        // Grant withheld in cycles 3..5.
        run_fill(16'h1234, 3, 5, -1, -1, 40, d, w, b, bb, le);
        chk("gap_done_cycle", 32'(d), 32'd15);
        chk("gap_writes", 32'(w), 32'd8);

        // Second miss during a fill is ignored.
        run_fill(16'h1234, -1, -1, -1, 4, 40, d, w, b, bb, le);
        chk("miss2_done_cycle", 32'(d), 32'd12);
        chk("miss2_base", 32'(bb), 32'd0);

        // Reset in cycle 6 of a fill; stale returns must be ignored.
        run_fill(16'h1234, -1, -1, 6, -1, 25, d, w, b, bb, le);
        chk("rst_no_done", 32'(d), 32'hFFFF_FFFF);
        chk("rst_late_events", 32'(le), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (!m_active && due_q.size() == 0 && ($urandom % 8) == 0)
                lat = int'($urandom_range(1, 6));
            tick(($urandom % 4) == 0, 16'($urandom), ($urandom % 10) < 7,
                 ($urandom % 250) == 0, ($urandom % 6) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling engine that refills one 16-byte cache block (8 halfwords) from the 4-cycle pipelined main memory. One instance sits between each cache (instruction and data) and the shared memory port. It takes a miss from the cache, issues eight sequential word reads while the memory arbiter grants the port, and streams returned words into the cache data array. It finishes with a single tag-array write and a completion pulse for the arbiter.

## Interface
Parameters:
- WORDS_PER_BLOCK, 8, halfwords per block; fixes counter width at 3 bits and the block offset at 4 address bits.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
- miss_address  in  16  byte address that missed; sampled with miss_detected.
- mem_grant  in  1  arbiter allows this instance to issue a read this cycle.
- memory_data_valid  in  1  memory returns a word for this instance; already qualified by grant ownership.
- memory_data  in  16  returned word.
- fsm_busy  out  1  stall request to the pipeline.
- mem_read_req  out  1  requests a read at memory_address this cycle.
- memory_address  out  16  byte address of the word being requested.
- write_data_array  out  1  write memory_data into the cache data array at block_word_idx.
- block_word_idx  out  3  halfword index within the block for the data-array write.
- write_tag_array  out  1  write the tag and set valid for the block.
- fill_done  out  1  one-cycle completion pulse to the arbiter.

## Operation
- States: IDLE, FETCH, DRAIN.
- Registers:
  - base: miss_address[15:4].
  - issue_cnt: 3 bits, plus an issue_all flag.
  - rcv_cnt: 3 bits.
- IDLE:
  - fsm_busy = miss_detected, combinational, so the pipeline stalls in the miss cycle.
  - On miss_detected: latch base, clear both counters, go to FETCH.
- FETCH:
  - mem_read_req = mem_grant.
  - memory_address = {base, issue_cnt, 1'b0}.
  - Each granted cycle increments issue_cnt.
  - On the 8th issue: set issue_all and go to DRAIN.
  - Grant low: no request, no increment, counters hold.
- FETCH and DRAIN, data return:
  - On memory_data_valid: write_data_array=1 and block_word_idx=rcv_cnt; rcv_cnt increments.
  - A valid when received count equals issued count is spurious and is ignored: no write, no increment.
- Last word: memory_data_valid with rcv_cnt==7.
  - Asserts write_data_array, write_tag_array and fill_done in the same cycle.
  - Next state is IDLE.
- fsm_busy = 1 in FETCH and DRAIN.
- miss_detected or miss_address changes while not in IDLE are ignored; base is stable for the whole fill.
- Words arrive in issue order. rcv_cnt wraps 7->0 only on the completing write.

## Timing
- Reset values: state IDLE, counters 0, issue_all 0; every registered output 0.
- Reset mid-fill: return to IDLE in the next cycle. No tag write happens and no fill_done is pulsed. Outstanding data-valids after reset are ignored because the state is IDLE.
- Continuous grant, memory latency L, miss in cycle 0:
  - Requests issue in cycles 1..8.
  - Data writes occur in cycles 1+L..8+L.
  - fill_done occurs in cycle 8+L.
  - fsm_busy is low from cycle 9+L, unless a new miss arrives then.
- For L=4: fill_done in cycle 12, 13 busy cycles total (0..12).
- Every cycle that grant is withdrawn in FETCH delays completion by exactly one cycle.
- No combinational path from memory_data to any control output except through memory_data_valid.

## Structure
- Shared package holds:
  - state encoding (IDLE, FETCH, DRAIN);
  - BLOCK_OFFSET_BITS = 4;
  - WORD_IDX_BITS = 3.
- The icache and dcache instances and the arbiter use the same package.
- One natural sub-module, word_counter: 3-bit counter with synchronous clear, enable and terminal-count output. It is instantiated twice, once for issue and once for receive.

## Test plan
- Miss at 0x1234, continuous grant, L=4:
  - Addresses 0x1230..0x123E issued in cycles 1..8.
  - Eight data writes with idx 0..7.
  - write_tag_array and fill_done in cycle 12 only.
  - fsm_busy is 1 in cycles 0..12.
- Grant withheld in cycles 3..5:
  - No mem_read_req in those cycles.
  - Addresses stay monotonic.
  - fill_done in cycle 15.
- Reset asserted in cycle 6 during FETCH: outputs are 0 in cycle 7, later data-valids produce no writes, and no tag write or fill_done occurs.
- Second miss_detected (0xABCD) in cycle 4 of a fill: ignored, and all addresses keep base 0x123.
- Spurious memory_data_valid in IDLE: no write_data_array, state remains IDLE.
- Back-to-back misses: a new miss in the cycle after fill_done starts a fresh fill with counters at 0.
